// File: rtl/stac_tap_pkg.sv
// stac_tap_pkg: shared types and constants for the STAC TAP driver
package stac_tap_pkg;
  localparam int IR_LEN_DEF = 8;
  localparam int DR_MAX_DEF = 33;
  localparam int LEN_W_DEF = 6;
  localparam int TLR_CYCLES_DEF = 5;
  localparam logic [7:0] IR_SEL_TDRRW = 8'h1A;
  localparam logic [7:0] IR_SEL_TDRR = 8'h1B;
  localparam logic [32:0] TDRR_CAPTURE = 33'hCA;
  typedef enum logic [3:0] {
    TLR, RTI_ENTRY, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT_ENTRY, SHIFT, EXIT1, UPDATE
  } tap_state_e;
  function automatic logic tms_of(input tap_state_e s, input logic last);
    return (s inside {TLR, SEL_DR, SEL_IR, EXIT1}) || (s == SHIFT && last);
  endfunction
endpackage

// File: rtl/stac_tap_shifter.sv
// stac_tap_shifter: parallel-load WSI source and indexed WSO capture register
module stac_tap_shifter
  import stac_tap_pkg::*;
#(
  parameter int W = DR_MAX_DEF,
  parameter int IW = LEN_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic          cap_en,
  input  logic [IW-1:0] cap_idx,
  input  logic          wso,
  input  logic [IW-1:0] out_idx,
  output logic          out_bit,
  output logic [W-1:0]  cap
);
  logic [W-1:0] data_q;
  assign out_bit = data_q[out_idx];
  // latch shift-in data on command acceptance; capture WSO bits by index, cleared on load
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_q <= '0;
      cap <= '0;
    end else if (load) begin
      data_q <= load_data;
      cap <= '0;
    end else if (cap_en) cap[cap_idx] <= wso;
endmodule

// File: rtl/stac_tap_driver.sv
// stac_tap_driver: turns word-level IR/DR scan commands into TMS/WSI streams and collects WSO
module stac_tap_driver
  import stac_tap_pkg::*;
#(
  parameter int IR_LEN = IR_LEN_DEF,
  parameter int DR_MAX = DR_MAX_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int TLR_CYCLES = TLR_CYCLES_DEF
) (
  input  logic              TCLK,
  input  logic              TRESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_is_ir,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DR_MAX-1:0] cmd_data,
  input  logic              tap_reset_req,
  output logic              rsp_valid,
  output logic [DR_MAX-1:0] rsp_data,
  output logic              busy,
  output logic              TMS,
  output logic              WSI,
  input  logic              WSO
);
  tap_state_e state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_eff, out_idx, cap_idx;
  logic ir_q, idle_q, accept, out_bit, tms_d, wsi_d, rsp_valid_d;
  assign cmd_ready = idle_q & ~tap_reset_req;
  assign accept = cmd_valid & cmd_ready;
  assign len_eff = cmd_is_ir ? LEN_W'(IR_LEN) : (cmd_len > LEN_W'(DR_MAX) ? LEN_W'(DR_MAX) : cmd_len);
  assign out_idx = len_q - cnt_d - LEN_W'(1);
  assign cap_idx = len_q - cnt_q - LEN_W'(1);
  // state and bit/cycle counter register
  always_ff @(posedge TCLK or negedge TRESETN)
    if (!TRESETN) begin
      state_q <= TLR;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  // next-state: TLR walk, command dispatch, TAP path and shift countdown
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      TLR: begin
        state_d = (cnt_q == LEN_W'(TLR_CYCLES - 1)) ? RTI_ENTRY : TLR;
        cnt_d = cnt_q + LEN_W'(1);
      end
      RTI_ENTRY: state_d = IDLE;
      IDLE:
        if (tap_reset_req) begin
          state_d = TLR;
          cnt_d = '0;
        end else if (accept && len_eff != '0) state_d = SEL_DR;
      SEL_DR: state_d = ir_q ? SEL_IR : CAPTURE;
      SEL_IR: state_d = CAPTURE;
      CAPTURE: state_d = SHIFT_ENTRY;
      SHIFT_ENTRY: begin
        state_d = SHIFT;
        cnt_d = len_q - LEN_W'(1);
      end
      SHIFT:
        if (cnt_q == '0) state_d = EXIT1;
        else cnt_d = cnt_q - LEN_W'(1);
      EXIT1: state_d = UPDATE;
      UPDATE: state_d = IDLE;
      default: state_d = TLR;
    endcase
  end
  // output decode from the upcoming state so the pins are registered alongside it
  always_comb begin
    tms_d = tms_of(state_d, cnt_d == '0);
    wsi_d = (state_d == SHIFT) && out_bit;
    rsp_valid_d = (state_q == UPDATE) || (accept && len_eff == '0);
  end
  // registered pins and status flags
  always_ff @(posedge TCLK or negedge TRESETN)
    if (!TRESETN) begin
      TMS <= 1'b1;
      WSI <= 1'b0;
      rsp_valid <= 1'b0;
      busy <= 1'b1;
      idle_q <= 1'b0;
    end else begin
      TMS <= tms_d;
      WSI <= wsi_d;
      rsp_valid <= rsp_valid_d;
      busy <= state_d != IDLE;
      idle_q <= state_d == IDLE;
    end
  // latch command kind and effective length on acceptance
  always_ff @(posedge TCLK or negedge TRESETN)
    if (!TRESETN) begin
      ir_q <= 1'b0;
      len_q <= '0;
    end else if (accept) begin
      ir_q <= cmd_is_ir;
      len_q <= len_eff;
    end
  stac_tap_shifter #(.W(DR_MAX), .IW(LEN_W)) u_shifter (
    .clk(TCLK),
    .rst_n(TRESETN),
    .load(accept),
    .load_data(cmd_data),
    .cap_en(state_q == SHIFT),
    .cap_idx(cap_idx),
    .wso(WSO),
    .out_idx(out_idx),
    .out_bit(out_bit),
    .cap(rsp_data)
  );
endmodule

// File: tb/tb_stac_tap_driver.sv
// tb_stac_tap_driver: directed and random scans against a pin-level STAC model and command scoreboard
module tb_stac_tap_driver;
  import stac_tap_pkg::*;
  logic TCLK = 1'b0, TRESETN = 1'b1, cmd_valid = 1'b0, cmd_is_ir = 1'b0, tap_reset_req = 1'b0;
  logic [5:0] cmd_len = '0;
  logic [32:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, busy, TMS, WSI, WSO;
  logic [32:0] rsp_data;
  int vectors = 0, miscompares = 0;
  logic tms_tr [100];
  logic wsi_tr [100];
  logic [7:0] sel_ir = 8'hFF;
  logic [32:0] tdrrw_exp = '0;

  stac_tap_driver dut (
    .TCLK(TCLK), .TRESETN(TRESETN), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_data(cmd_data), .tap_reset_req(tap_reset_req),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .TMS(TMS), .WSI(WSI), .WSO(WSO)
  );

  always #5 TCLK = ~TCLK;

  // STAC side: standard IEEE 1149.1 TAP controller with IR, TDRR (read-only) and TDRRW
  typedef enum int {T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
                    T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR} tap_t;
  tap_t tap = T_TLR;
  logic [7:0] ir = 8'hFF, ir_sr = '0;
  logic [32:0] dr_sr = '0, tdrrw = '0;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      T_TLR:  return m ? T_TLR : T_RTI;
      T_RTI:  return m ? T_SDR : T_RTI;
      T_SDR:  return m ? T_SIR : T_CDR;
      T_CDR:  return m ? T_E1DR : T_SHDR;
      T_SHDR: return m ? T_E1DR : T_SHDR;
      T_E1DR: return m ? T_UDR : T_PDR;
      T_PDR:  return m ? T_E2DR : T_PDR;
      T_E2DR: return m ? T_UDR : T_SHDR;
      T_UDR:  return m ? T_SDR : T_RTI;
      T_SIR:  return m ? T_TLR : T_CIR;
      T_CIR:  return m ? T_E1IR : T_SHIR;
      T_SHIR: return m ? T_E1IR : T_SHIR;
      T_E1IR: return m ? T_UIR : T_PIR;
      T_PIR:  return m ? T_E2IR : T_PIR;
      T_E2IR: return m ? T_UIR : T_SHIR;
      default: return m ? T_SDR : T_RTI;
    endcase
  endfunction

  always @(posedge TCLK) begin
    tap <= tap_next(tap, TMS);
    case (tap)
      T_TLR:  ir <= 8'hFF;
      T_CIR:  ir_sr <= 8'h01;
      T_SHIR: ir_sr <= {WSI, ir_sr[7:1]};
      T_UIR:  ir <= ir_sr;
      T_CDR:  dr_sr <= (ir == IR_SEL_TDRR) ? TDRR_CAPTURE : (ir == IR_SEL_TDRRW) ? tdrrw : '0;
      T_SHDR: dr_sr <= (ir == IR_SEL_TDRR || ir == IR_SEL_TDRRW) ? {WSI, dr_sr[32:1]} : {32'b0, WSI};
      T_UDR:  if (ir == IR_SEL_TDRRW) tdrrw <= dr_sr;
      default: ;
    endcase
  end
  assign WSO = (tap == T_SHIR) ? ir_sr[0] : (tap == T_SHDR) ? dr_sr[0] : 1'b0;

  function automatic logic [32:0] r33();
    return {1'($urandom_range(0, 1)), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // command-level expectation: response and latency from the scan rules, tracking IR and TDRRW contents
  task automatic predict(input logic isir, input logic [5:0] len, input logic [32:0] d,
                         output logic [32:0] rsp, output int lat);
    int l;
    logic [65:0] m, r;
    if (isir) begin
      sel_ir = d[7:0];
      rsp = 33'h1;
      lat = IR_LEN_DEF + 6;
      return;
    end
    l = (len > 6'd33) ? 33 : int'(len);
    lat = (l == 0) ? 0 : l + 5;
    m = (66'd1 << l) - 66'd1;
    if (l == 0) r = '0;
    else if (sel_ir == IR_SEL_TDRR) r = {33'b0, TDRR_CAPTURE} & m;
    else if (sel_ir == IR_SEL_TDRRW) begin
      r = {33'b0, tdrrw_exp} & m;
      tdrrw_exp = 33'(({33'b0, tdrrw_exp} >> l) | (({33'b0, d} & m) << (33 - l)));
    end else r = {32'b0, d, 1'b0} & m;
    rsp = r[32:0];
  endtask

  task automatic send(input logic isir, input logic [5:0] len, input logic [32:0] d);
    int n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge TCLK);
      n++;
    end
    chk("ready_wait", 64'(n < 300), 64'd1);
    cmd_valid = 1'b1;
    cmd_is_ir = isir;
    cmd_len = len;
    cmd_data = d;
    @(posedge TCLK);
    #1;
    cmd_valid = 1'b0;
    cmd_is_ir = 1'($urandom);
    cmd_len = 6'($urandom);
    cmd_data = r33();
  endtask

  task automatic run(input string tag, input logic isir, input logic [5:0] len, input logic [32:0] d);
    logic [32:0] exp_d;
    int exp_lat, lat;
    predict(isir, len, d, exp_d, exp_lat);
    send(isir, len, d);
    lat = -1;
    for (int j = 0; j < 100; j++) begin
      @(negedge TCLK);
      tms_tr[j] = TMS;
      wsi_tr[j] = WSI;
      if (rsp_valid) begin
        lat = j;
        break;
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_data"}, 64'(rsp_data), 64'(exp_d));
  endtask

  task automatic check_tlr(input string tag);
    for (int k = 1; k <= 7; k++) begin
      chk({tag, "_tms"}, 64'(TMS), 64'(k <= 5));
      chk({tag, "_ready"}, 64'(cmd_ready), 64'(k == 7));
      chk({tag, "_busy"}, 64'(busy), 64'(k < 7));
      chk({tag, "_wsi"}, 64'(WSI), 64'd0);
      chk({tag, "_rspv"}, 64'(rsp_valid), 64'd0);
      if (k < 7) @(negedge TCLK);
    end
  endtask

  initial begin
    logic [13:0] exp_tms;
    logic [7:0] code;
    logic [32:0] d;
    #2 TRESETN = 1'b0;
    repeat (3) @(negedge TCLK);
    chk("rst_tms", 64'(TMS), 64'd1);
    chk("rst_wsi", 64'(WSI), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rspv", 64'(rsp_valid), 64'd0);
    chk("rst_rspd", 64'(rsp_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    TRESETN = 1'b1;
    check_tlr("tlr");
    exp_tms = 14'b01100000000011;
    code = IR_SEL_TDRR;
    run("ir_tdrr", 1'b1, 6'd0, 33'(IR_SEL_TDRR));
    for (int j = 0; j < 14; j++) chk("ir_tms_trace", 64'(tms_tr[j]), 64'(exp_tms[j]));
    for (int j = 0; j < 8; j++) chk("ir_wsi_trace", 64'(wsi_tr[4 + j]), 64'(code[j]));
    run("tdrr_rd", 1'b0, 6'd33, 33'h0);
    chk("tdrr_const", 64'(rsp_data), 64'h0CA);
    run("ir_tdrrw", 1'b1, 6'd0, 33'(IR_SEL_TDRRW));
    d = 33'h1_2345_6789;
    run("tdrrw_wr", 1'b0, 6'd33, d);
    for (int j = 0; j < 33; j++) chk("dr_wsi_trace", 64'(wsi_tr[3 + j]), 64'(d[j]));
    run("tdrrw_rb", 1'b0, 6'd33, d);
    chk("tdrrw_readback", 64'(rsp_data), 64'h1_2345_6789);
    run("len0", 1'b0, 6'd0, r33());
    chk("len0_tms", 64'(tms_tr[0]), 64'd0);
    run("len40", 1'b0, 6'd40, r33());
    tap_reset_req = 1'b1;
    cmd_valid = 1'b1;
    cmd_len = 6'd5;
    #1 chk("req_ready", 64'(cmd_ready), 64'd0);
    @(posedge TCLK);
    #1;
    tap_reset_req = 1'b0;
    cmd_valid = 1'b0;
    @(negedge TCLK);
    sel_ir = 8'hFF;
    check_tlr("req_tlr");
    run("bypass", 1'b0, 6'd12, r33());
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: code = IR_SEL_TDRR;
          1: code = IR_SEL_TDRRW;
          default: code = 8'($urandom);
        endcase
        run("rnd_ir", 1'b1, 6'($urandom), {25'($urandom), code});
      end else run("rnd_dr", 1'b0, 6'($urandom_range(0, 40)), r33());
    end
    run("ir_tdrrw2", 1'b1, 6'd0, 33'(IR_SEL_TDRRW));
    send(1'b0, 6'd33, r33());
    repeat (14) @(negedge TCLK);
    chk("pre_rst_tms", 64'(TMS), 64'd0);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    TRESETN = 1'b0;
    #1;
    chk("mid_rst_tms", 64'(TMS), 64'd1);
    chk("mid_rst_rspv", 64'(rsp_valid), 64'd0);
    chk("mid_rst_wsi", 64'(WSI), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd1);
    repeat (2) @(negedge TCLK);
    chk("mid_rst_rspv2", 64'(rsp_valid), 64'd0);
    TRESETN = 1'b1;
    sel_ir = 8'hFF;
    check_tlr("rst2_tlr");
    run("post_ir", 1'b1, 6'd0, 33'(IR_SEL_TDRR));
    run("post_dr", 1'b0, 6'd33, r33());
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stac_tap_driver.md
Name: stac_tap_driver

Overview:
- Host-side TAP sequencer for the STAC test-access block: turns word-level scan commands into TMS/WSI bit streams and collects the WSO response.
- Performs IR scans (8-bit instruction load) and DR scans (1..33 bits) through the standard TAP path, then returns to Run-Test/Idle.
- Sits between the BIST/gasket command logic and the STAC serial pins, in the TCLK domain.

Parameters:
- IR_LEN, 8, instruction register length in bits.
- DR_MAX, 33, longest supported DR scan in bits.
- LEN_W, 6, width of the command length field; must satisfy 2^LEN_W > DR_MAX.
- TLR_CYCLES, 5, number of TMS=1 cycles used to force Test-Logic-Reset.

Ports:
- TCLK  in  1  scan clock; all state updates on the rising edge.
- TRESETN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  driver accepts a command this cycle.
- cmd_is_ir  in  1  1 = IR scan (length forced to IR_LEN), 0 = DR scan.
- cmd_len  in  LEN_W  DR scan length; ignored for IR scans.
- cmd_data  in  DR_MAX  shift-in data, LSB shifted first.
- tap_reset_req  in  1  request a TLR resynchronisation sequence.
- rsp_valid  out  1  single-cycle pulse: response data is valid.
- rsp_data  out  DR_MAX  captured WSO bits, right-aligned, upper bits zero.
- busy  out  1  high whenever the driver is not in IDLE.
- TMS  out  1  to the STAC TMS pin.
- WSI  out  1  to the STAC WSI pin.
- WSO  in  1  from the STAC WSO pin.

Behaviour:
- Registered outputs:
  - All outputs are registered on the TCLK rising edge.
  - The STAC samples each TMS/WSI value at the rising edge that ends the cycle in which it is driven.
- Reset values (TRESETN low, asynchronous): TMS=1, WSI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1, state=TLR.
- Reset mid-scan: the command is discarded, no rsp_valid pulse is issued, and the sequence restarts from TLR.
- TLR sequence:
  - TMS=1 for TLR_CYCLES cycles, then TMS=0 for 1 cycle (Run-Test/Idle).
  - The driver then enters IDLE.
- IDLE:
  - TMS=0, WSI=0, busy=0.
  - cmd_ready=1 unless tap_reset_req=1.
- Command acceptance:
  - A command is accepted when cmd_valid & cmd_ready.
  - On acceptance the driver latches cmd_is_ir, the effective length and cmd_data, and clears rsp_data.
- Precedence: tap_reset_req=1 in IDLE takes precedence over cmd_valid and starts the TLR sequence.
- Effective length:
  - IR scan: IR_LEN.
  - DR scan: cmd_len clamped to DR_MAX.
  - DR scan with cmd_len=0: accepted, no TAP activity, rsp_valid pulses the next cycle with rsp_data=0.
- States: TLR, RTI_ENTRY, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT_ENTRY, SHIFT, EXIT1, UPDATE.
- TMS sequence driven per state:
  - DR scan: SEL_DR(1), CAPTURE(0), SHIFT_ENTRY(0), SHIFT×len, EXIT1(1), UPDATE(0), then IDLE.
  - IR scan: SEL_DR(1), SEL_IR(1), CAPTURE(0), SHIFT_ENTRY(0), SHIFT×len, EXIT1(1), UPDATE(0), then IDLE.
- SHIFT phase:
  - The bit counter counts down from len-1.
  - WSI = latched data bit i, LSB first.
  - TMS=0 on bits 0..len-2 and TMS=1 on bit len-1, which exits to Exit1.
  - WSO is sampled at the rising edge that ends the cycle carrying WSI bit i and is stored into rsp_data[i].
- Latency from acceptance edge to rsp_valid:
  - DR scan: len+5 cycles.
  - IR scan: IR_LEN+6 cycles.
  - rsp_valid is asserted in the first IDLE cycle.
- Back-to-back commands: cmd_ready is high in that same IDLE cycle, so a new command may be accepted concurrently with rsp_valid.
- cmd_* inputs are ignored while busy.

Decomposition:
- Shared package stac_tap_pkg contains:
  - the state enum;
  - IR_LEN, DR_MAX and TLR_CYCLES defaults;
  - the instruction codes IR_SEL_TDRRW and IR_SEL_TDRR that select the two STAC data registers;
  - the TDRR capture constant 33'hCA.
- One sub-module, stac_tap_shifter, is natural: a DR_MAX-bit parallel-load/serial-out register for WSI combined with a serial-in capture register for WSO, indexed by the bit counter.

Test Plan:
- Reset: release TRESETN → TMS=1 for 5 cycles, then 0; cmd_ready rises on cycle 7; WSI=0 throughout.
- IR scan of IR_SEL_TDRR → TMS trace 1,1,0,0,0×7,1,1,0; WSI carries the code LSB-first; rsp_valid pulses 14 cycles after acceptance.
- DR scan after the TDRR select, len=33, data=0 → rsp_data=33'h0_0000_00CA; rsp_valid exactly 38 cycles after acceptance.
- DR scan after the TDRRW select, len=33, data=33'h1_2345_6789, followed by a second identical scan → second rsp_data=33'h1_2345_6789 (readback).
- Edge cases:
  - cmd_len=0 → rsp_valid next cycle with data 0 and TMS held 0.
  - cmd_len=40 → clamped to 33-bit scan.
  - tap_reset_req and cmd_valid in the same IDLE cycle → TLR sequence runs, command not accepted.
- TRESETN asserted during SHIFT bit 10 → TMS=1 immediately, no rsp_valid; after release, the full TLR sequence runs and a new scan completes correctly.
